// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// State enum, opcode constants and datapath mux select encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_EXEC_U = 4'd5,
    ST_ADDR   = 4'd6,
    ST_MEM_RD = 4'd7,
    ST_MEM_WR = 4'd8,
    ST_WB_ALU = 4'd9,
    ST_WB_MEM = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JAL    = 4'd12,
    ST_JALR   = 4'd13,
    ST_TRAP   = 4'd14
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALUO = 2'b00;
  localparam logic [1:0] WB_MEMD = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Cycle and retired-instruction counters for the control FSM.
// Only instantiated when CTRL_PERF_CNT_EN is defined.
module ctrl_perf_cnt
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           state,
  input  state_t           state_next,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic run;
  logic retire;

  assign run = (state != ST_RESET) && (state != ST_TRAP);
  assign retire = (state_next == ST_FETCH) &&
                  (state != ST_FETCH) &&
                  (state != ST_RESET);

  // Count active cycles and instruction completions; wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (run)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)
        instret_cnt <= instret_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with state-decoded datapath controls.
// Optional performance counters: define CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t cur;
  state_t nxt;

  assign state = cur;

  // State register; reset forces all state-decoded outputs low at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cur <= ST_RESET;
    else
      cur <= nxt;
  end

  // Next-state and control decode from the current state.
  always_comb begin
    nxt          = cur;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUO;
    alu_op       = ALU_ADD;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RS2;
    illegal      = 1'b0;
    unique case (cur)
      ST_RESET: nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R:      nxt = ST_EXEC_R;
          OP_I:      nxt = ST_EXEC_I;
          OP_LUI:    nxt = ST_EXEC_U;
          OP_AUIPC:  nxt = ST_EXEC_U;
          OP_LOAD:   nxt = ST_ADDR;
          OP_STORE:  nxt = ST_ADDR;
          OP_BRANCH: nxt = ST_BRANCH;
          OP_JAL:    nxt = ST_JAL;
          OP_JALR:   nxt = ST_JALR;
          default:   nxt = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        alu_op = ALU_FUNCT;
        nxt    = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_op    = ALU_FUNCT;
        alu_src_b = SRCB_IMM;
        nxt       = ST_WB_ALU;
      end
      ST_EXEC_U: begin
        alu_src_b = SRCB_IMM;
        alu_src_a = (opcode == OP_AUIPC);
        nxt       = ST_WB_ALU;
      end
      ST_ADDR: begin
        alu_src_b = SRCB_IMM;
        nxt = (opcode == OP_STORE) ? ST_MEM_WR
                                   : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        if (mem_ready)
          nxt = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_sel_data = 1'b1;
        if (mem_ready)
          nxt = ST_FETCH;
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
        nxt       = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEMD;
        nxt       = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op   = ALU_BR;
        pc_write = branch_taken;
        pc_src   = PC_REL;
        nxt      = ST_FETCH;
      end
      ST_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = PC_REL;
        nxt       = ST_FETCH;
      end
      ST_JALR: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
        pc_src    = PC_ALU;
        nxt       = ST_FETCH;
      end
      ST_TRAP: illegal = 1'b1;
      default: nxt = ST_TRAP;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  ctrl_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .state      (cur),
    .state_next (nxt),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a per-cycle scoreboard.
// Counter checks follow CTRL_PERF_CNT_EN.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel_data;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic [1:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_sel_data(mem_sel_data),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .alu_op      (alu_op),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .illegal     (illegal),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       st;
    logic [15:0]      vec;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ins;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  state_t prev;
  logic [CNT_W-1:0] m_cyc;
  logic [CNT_W-1:0] m_ins;

  // Control outputs packed in a fixed order for comparison.
  function automatic logic [15:0] pack(
    logic rq, logic we, logic sd, logic ir, logic pw,
    logic [1:0] ps, logic rw, logic [1:0] ws,
    logic [1:0] ao, logic sa, logic [1:0] sb, logic il);
    return {rq, we, sd, ir, pw, ps, rw, ws, ao, sa, sb, il};
  endfunction

  // Expected controls for a state, written from the state table.
  function automatic logic [15:0] exp_vec(
    state_t s, logic rdy, logic bt, logic [6:0] op);
    logic au;
    au = (op == 7'b0010111);
    case (s)
      ST_FETCH:  return pack(1,0,0,rdy,rdy,2'b00,0,2'b00,2'b00,0,2'b00,0);
      ST_EXEC_R: return pack(0,0,0,0,0,2'b00,0,2'b00,2'b10,0,2'b00,0);
      ST_EXEC_I: return pack(0,0,0,0,0,2'b00,0,2'b00,2'b10,0,2'b01,0);
      ST_EXEC_U: return pack(0,0,0,0,0,2'b00,0,2'b00,2'b00,au,2'b01,0);
      ST_ADDR:   return pack(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b01,0);
      ST_MEM_RD: return pack(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,0);
      ST_MEM_WR: return pack(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,0);
      ST_WB_ALU: return pack(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,0);
      ST_WB_MEM: return pack(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,0);
      ST_BRANCH: return pack(0,0,0,0,bt,2'b01,0,2'b00,2'b01,0,2'b00,0);
      ST_JAL:    return pack(0,0,0,0,1,2'b01,1,2'b10,2'b00,0,2'b00,0);
      ST_JALR:   return pack(0,0,0,0,1,2'b10,1,2'b10,2'b00,0,2'b01,0);
      ST_TRAP:   return pack(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,1);
      default:   return 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] dut_vec();
    return pack(mem_req, mem_we, mem_sel_data, ir_write,
                pc_write, pc_src, reg_write, wb_sel,
                alu_op, alu_src_a, alu_src_b, illegal);
  endfunction

  task automatic check_top(input string tag);
    exp_t e;
    e = q.pop_front();
    tests++;
    assert (state === e.st) else begin
      fails++;
      $error("FAIL %s state got %0d exp %0d", tag, state, e.st);
    end
    tests++;
    assert (dut_vec() === e.vec) else begin
      fails++;
      $error("FAIL %s ctrl got %04h exp %04h", tag, dut_vec(), e.vec);
    end
    tests++;
    assert (cycle_cnt === e.cyc) else begin
      fails++;
      $error("FAIL %s cycle_cnt got %0d exp %0d", tag, cycle_cnt, e.cyc);
    end
    tests++;
    assert (instret_cnt === e.ins) else begin
      fails++;
      $error("FAIL %s instret got %0d exp %0d", tag, instret_cnt, e.ins);
    end
  endtask

  task automatic model_reset();
    prev  = ST_RESET;
    m_cyc = '0;
    m_ins = '0;
  endtask

  // One clock of stimulus: drive, predict, compare, advance.
  task automatic step(input state_t es, input logic rdy,
                      input logic bt, input string tag);
    exp_t e;
    mem_ready    = rdy;
    branch_taken = bt;
`ifdef CTRL_PERF_CNT_EN
    if (prev != ST_RESET && prev != ST_TRAP)
      m_cyc = m_cyc + 1'b1;
    if (es == ST_FETCH && prev != ST_FETCH && prev != ST_RESET)
      m_ins = m_ins + 1'b1;
`endif
    e.st  = es;
    e.vec = exp_vec(es, rdy, bt, opcode);
    e.cyc = m_cyc;
    e.ins = m_ins;
    q.push_back(e);
    #1;
    check_top(tag);
    prev = es;
    @(posedge clk);
    #1;
  endtask

  task automatic simple4(input logic [6:0] op, input state_t ex,
                         input string tag);
    opcode = op;
    step(ST_FETCH, 1, 0, tag);
    step(ST_DECODE, 1, 0, tag);
    step(ex, 1, 0, tag);
    step(ST_WB_ALU, 1, 0, tag);
  endtask

  initial begin
    rst = 1'b1;
    opcode = 7'h0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    model_reset();
    #1;
    q.push_back('{4'd0, 16'h0, '0, '0});
    check_top("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(ST_RESET, 1, 0, "post_rst");

    simple4(7'b0110011, ST_EXEC_R, "add");
    simple4(7'b0010011, ST_EXEC_I, "addi");
    simple4(7'b0110111, ST_EXEC_U, "lui");
    simple4(7'b0010111, ST_EXEC_U, "auipc");

    opcode = 7'b0000011;
    step(ST_FETCH, 0, 0, "lw_fwait");
    step(ST_FETCH, 1, 0, "lw");
    step(ST_DECODE, 0, 0, "lw");
    step(ST_ADDR, 1, 0, "lw");
    step(ST_MEM_RD, 0, 0, "lw_w1");
    step(ST_MEM_RD, 0, 0, "lw_w2");
    step(ST_MEM_RD, 1, 0, "lw_rdy");
    step(ST_WB_MEM, 0, 0, "lw_wb");

    opcode = 7'b0100011;
    step(ST_FETCH, 1, 0, "sw");
    step(ST_DECODE, 1, 0, "sw");
    step(ST_ADDR, 0, 0, "sw");
    step(ST_MEM_WR, 1, 0, "sw_wr");

    opcode = 7'b1100011;
    step(ST_FETCH, 1, 1, "beq_t");
    step(ST_DECODE, 1, 1, "beq_t");
    step(ST_BRANCH, 0, 1, "beq_t");
    step(ST_FETCH, 1, 0, "beq_n");
    step(ST_DECODE, 1, 0, "beq_n");
    step(ST_BRANCH, 1, 0, "beq_n");

    opcode = 7'b1101111;
    step(ST_FETCH, 1, 0, "jal");
    step(ST_DECODE, 1, 0, "jal");
    step(ST_JAL, 1, 0, "jal");

    opcode = 7'b1100111;
    step(ST_FETCH, 1, 0, "jalr");
    step(ST_DECODE, 1, 0, "jalr");
    step(ST_JALR, 1, 0, "jalr");

    opcode = 7'b0000000;
    step(ST_FETCH, 1, 0, "ill");
    step(ST_DECODE, 1, 0, "ill");
    step(ST_TRAP, 1, 0, "trap1");
    opcode = 7'b0110011;
    step(ST_TRAP, 1, 1, "trap2");
    step(ST_TRAP, 0, 0, "trap3");

    rst = 1'b1;
    #1;
    model_reset();
    q.push_back('{4'd0, 16'h0, '0, '0});
    check_top("trap_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(ST_RESET, 0, 0, "rst2");

    opcode = 7'b0100011;
    step(ST_FETCH, 1, 0, "sw2");
    step(ST_DECODE, 1, 0, "sw2");
    step(ST_ADDR, 1, 0, "sw2");
    step(ST_MEM_WR, 0, 0, "sw2_wait");
    mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    assert (mem_req === 1'b0 && mem_we === 1'b0) else begin
      fails++;
      $error("FAIL async_rst req/we got %b%b exp 00", mem_req, mem_we);
    end
    tests++;
    assert (state === 4'd0) else begin
      fails++;
      $error("FAIL async_rst state got %0d exp 0", state);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(ST_RESET, 1, 0, "rst3");
    step(ST_FETCH, 1, 0, "resume");
    step(ST_DECODE, 1, 0, "resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM that sequences the RV32I datapath (inst/data memory port, reg_file, alu, pc, imm_gen) through fetch, decode, execute, memory and writeback phases. It replaces the single-cycle opcode decode with state-driven Moore control signals. Memory accesses use a single shared port with a req/ready handshake. The alu_ctrl block still derives alufn from alu_op, funct7 and funct3.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (used only with CTRL_PERF_CNT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory accepted/completed the current request
- branch_taken  in  1  branch compare result from alu/compare logic
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- mem_sel_data  out  1  0 = address is pc, 1 = address is alu_out
- ir_write  out  1  latch IR and old_pc
- pc_write  out  1  load pc
- pc_src  out  2  00 = pc+4, 01 = old_pc+imm, 10 = alu_out & ~1
- reg_write  out  1  reg_file write enable
- wb_sel  out  2  00 = alu_out, 01 = mem data, 10 = pc (equals old_pc+4)
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded
- alu_src_a  out  1  0 = rs1, 1 = old_pc (AUIPC); LUI uses 0 with a zeroed rs1 index in the datapath
- alu_src_b  out  2  00 = rs2, 01 = imm
- illegal  out  1  sticky, set on an unsupported opcode
- state  out  4  current state, for debug
- cycle_cnt  out  CNT_W  cycle counter
- instret_cnt  out  CNT_W  retired-instruction counter

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, TRAP.
- Outputs are decoded purely from state (Moore). Any output not listed for a state is 0.
- RESET → FETCH unconditionally.
- FETCH: mem_req=1, mem_sel_data=0. While mem_ready=0, stay in FETCH. When mem_ready=1, assert ir_write=1, pc_write=1, pc_src=00 and go to DECODE.
- DECODE: no outputs. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0110111 / 0010111 → EXEC_U
  - 0000011 / 0100011 → ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - any other opcode → TRAP
- EXEC_R: alu_op=10, alu_src_b=00 → WB_ALU.
- EXEC_I: alu_op=10, alu_src_b=01 → WB_ALU.
- EXEC_U: alu_op=00, alu_src_b=01, alu_src_a=1 only for AUIPC → WB_ALU.
- ADDR: alu_op=00, alu_src_b=01 → MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, mem_sel_data=1. Wait for mem_ready, then → WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, mem_sel_data=1. Wait for mem_ready, then → FETCH.
- WB_ALU: reg_write=1, wb_sel=00 → FETCH.
- WB_MEM: reg_write=1, wb_sel=01 → FETCH.
- BRANCH: alu_op=01, alu_src_b=00. pc_write=branch_taken, pc_src=01 → FETCH.
- JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01 → FETCH.
- JALR: reg_write=1, wb_sel=10, alu_op=00, alu_src_b=01, pc_write=1, pc_src=10 → FETCH.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until rst.

## Timing
- Reset values: state=RESET, every output 0, illegal=0, counters 0.
- rst asserted mid-instruction aborts it immediately. An outstanding mem_req drops asynchronously.
- Handshake: mem_req, mem_we and the address select stay stable until the edge where mem_ready=1 is sampled. mem_ready is ignored while mem_req=0.
- Latency with zero-wait memory:
  - R/I/U-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch / JAL / JALR: 3 cycles
  - each wait cycle adds 1.
- The first FETCH begins 1 cycle after rst deasserts.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - cycle_cnt increments on every cycle whose state is not RESET or TRAP.
  - instret_cnt increments on each transition into FETCH from a non-RESET state.
  - Both wrap modulo 2^CNT_W.
- CTRL_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- ctrl_pkg holds:
  - the state enum (4-bit encoding, RESET=0)
  - opcode constants
  - the pc_src, wb_sel, alu_op and alu_src_b encodings
- One sub-module, ctrl_perf_cnt, holds both counters. It is instantiated only under CTRL_PERF_CNT_EN.

## Test plan
- Reset, then ADD (0110011) with mem_ready=1 → FETCH, DECODE, EXEC_R, WB_ALU, FETCH. reg_write=1 only in WB_ALU. instret_cnt=1 after 4 cycles.
- LW with mem_ready low for 2 cycles in MEM_RD → mem_req held with mem_sel_data=1 for 3 cycles. reg_write with wb_sel=01 one cycle later. Total 7 cycles.
- BEQ with branch_taken=1, then branch_taken=0 → pc_write=1 with pc_src=01 in the first case; pc_write=0 in the second. Both take 3 cycles.
- JALR → in the JALR cycle: reg_write=1, wb_sel=10, pc_write=1, pc_src=10, alu_src_b=01.
- Opcode 0000000 → TRAP with illegal=1 held. cycle_cnt frozen. Only rst clears it.
- rst asserted during MEM_WR wait → mem_req and mem_we fall without a clock edge. FETCH resumes 1 cycle after release.
